// File: rtl/noc_pkt_pkg.sv
// Packet format shared by the traffic generator and the checker: header layout,
// payload LFSR and error-flag bit positions.
package noc_pkt_pkg;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int ERR_DATA = 0;
   localparam int ERR_LEN  = 1;
   localparam int ERR_SEQ  = 2;
   localparam int ERR_DEST = 3;

   typedef struct packed {
      logic [3:0] src;
      logic [7:0] seq;
      logic [7:0] len;
      logic [3:0] rsvd;
      logic [7:0] seed;
   } pkt_hdr_t;

   // Payload word k+1 is derived from word k by a right-shifting Galois LFSR.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
      return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
   endfunction

endpackage

// File: rtl/pkt_seq_table.sv
// Per-source expected sequence numbers: 16 entries of 8 bits, combinational
// read, single write port, synchronous clear.
module pkt_seq_table (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data
);

   logic [7:0] mem [16];

   // NOTE: this table is architecturally visible state (every source must restart
   // at SEQ 0), so unlike a data RAM it is reset; 16 flops per bit is cheap here.
   // NOTE: sequential state is always written with <= so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_checker.sv
// Receive-side AXI-Stream packet checker: validates header, LFSR payload, length,
// per-source sequence and TDEST, and keeps packet/error statistics.
module axis_pkt_checker
   import noc_pkt_pkg::*;
#(
   parameter int                TDATAW      = 32,
   parameter int                TDESTW      = 4,
   parameter logic [TDESTW-1:0] MY_ADDR     = TDESTW'(1),
   parameter int                NUM_PACKETS = 16,
   parameter int                CNTW        = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLEAR,
   input  logic              HOLD,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST,
   output logic [CNTW-1:0]   PKT_CNT,
   output logic [CNTW-1:0]   ERR_CNT,
   output logic [3:0]        ERR_FLAGS,
   output logic              PKT_OK,
   output logic              PKT_ERR,
   output logic              DONE
);

   localparam logic [1:0] ST_HDR   = 2'd0;
   localparam logic [1:0] ST_PAY   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]      state, state_nxt;
   logic [7:0]      remaining;
   logic [7:0]      lfsr;
   logic [3:0]      err_vec, beat_err, err_nxt;
   logic [7:0]      seq_rd;
   logic            accept, complete;
   logic [CNTW-1:0] pkt_cnt_inc, err_cnt_inc;
   pkt_hdr_t        hdr;

   assign AXIS_S_TREADY = !HOLD && !RST;
   assign accept        = AXIS_S_TVALID && AXIS_S_TREADY && !CLEAR;
   assign hdr           = pkt_hdr_t'(AXIS_S_TDATA[31:0]);
   assign pkt_cnt_inc   = (PKT_CNT == '1) ? PKT_CNT : PKT_CNT + CNTW'(1);
   assign err_cnt_inc   = (ERR_CNT == '1) ? ERR_CNT : ERR_CNT + CNTW'(1);

   pkt_seq_table u_seq_table (
      .clk     (CLK),
      .rst     (RST),
      .clear   (CLEAR),
      .rd_addr (hdr.src),
      .rd_data (seq_rd),
      .wr_en   (accept && (state == ST_HDR)),
      .wr_addr (hdr.src),
      .wr_data (hdr.seq + 8'd1)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      beat_err           = '0;
      state_nxt          = state;
      complete           = 1'b0;
      beat_err[ERR_DEST] = (AXIS_S_TDEST != MY_ADDR);
      case (state)
         ST_HDR: begin
            beat_err[ERR_SEQ]  = (hdr.seq != seq_rd);
            beat_err[ERR_LEN]  = (hdr.len == 8'd0) || AXIS_S_TLAST;
            beat_err[ERR_DATA] = (hdr.seed == 8'd0) || (hdr.rsvd != 4'd0);
            if (AXIS_S_TLAST)          complete  = 1'b1;
            else if (hdr.len == 8'd0)  state_nxt = ST_DRAIN;
            else                       state_nxt = ST_PAY;
         end
         ST_PAY: begin
            beat_err[ERR_DATA] = (AXIS_S_TDATA != {{(TDATAW-8){1'b0}}, lfsr});
            if (AXIS_S_TLAST) begin
               beat_err[ERR_LEN] = (remaining != 8'd1);
               complete          = 1'b1;
               state_nxt         = ST_HDR;
            end else if (remaining == 8'd1) begin
               beat_err[ERR_LEN] = 1'b1;
               state_nxt         = ST_DRAIN;
            end
         end
         default: begin
            // Overlong packet: discard until TLAST; the length error is already recorded.
            if (AXIS_S_TLAST) begin
               complete  = 1'b1;
               state_nxt = ST_HDR;
            end
         end
      endcase
      err_nxt = ((state == ST_HDR) ? 4'd0 : err_vec) | beat_err;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_HDR;
         remaining <= '0;
         lfsr      <= '0;
         err_vec   <= '0;
         PKT_CNT   <= '0;
         ERR_CNT   <= '0;
         ERR_FLAGS <= '0;
         PKT_OK    <= 1'b0;
         PKT_ERR   <= 1'b0;
         DONE      <= 1'b0;
      end else if (CLEAR) begin
         state     <= ST_HDR;
         remaining <= '0;
         lfsr      <= '0;
         err_vec   <= '0;
         PKT_CNT   <= '0;
         ERR_CNT   <= '0;
         ERR_FLAGS <= '0;
         PKT_OK    <= 1'b0;
         PKT_ERR   <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         PKT_OK  <= 1'b0;
         PKT_ERR <= 1'b0;
         if (accept) begin
            state   <= state_nxt;
            err_vec <= err_nxt;
            if (state == ST_HDR) begin
               remaining <= hdr.len;
               lfsr      <= hdr.seed;
            end else if (state == ST_PAY) begin
               remaining <= remaining - 8'd1;
               lfsr      <= lfsr8_next(lfsr);
            end
            if (complete) begin
               PKT_CNT <= pkt_cnt_inc;
               if (pkt_cnt_inc >= CNTW'(NUM_PACKETS)) DONE <= 1'b1;
               if (err_nxt == 4'd0) begin
                  PKT_OK <= 1'b1;
               end else begin
                  PKT_ERR   <= 1'b1;
                  ERR_CNT   <= err_cnt_inc;
                  ERR_FLAGS <= ERR_FLAGS | err_nxt;
               end
            end
         end
      end
   end

endmodule
